// File: rtl/usbdev_pkg.sv
// rtl/usbdev_pkg.sv - shared USB device types and default timing constants
package usbdev_pkg;

  typedef enum logic [2:0] {
    WAKE_IDLE      = 3'd0,
    WAKE_WAIT_IDLE = 3'd1,
    WAKE_DRIVE     = 3'd2,
    WAKE_HOST_WAIT = 3'd3
  } wake_state_e;

  localparam int unsigned USB_TIMER_W         = 15;
  localparam int unsigned SUSPEND_MIN_US_DEF  = 5000;
  localparam int unsigned RESUME_DRIVE_US_DEF = 2000;
  localparam int unsigned HOST_WAIT_US_DEF    = 30000;

  // Timer value seen in the cycle whose tick completes a window of `us` microseconds.
  function automatic logic [USB_TIMER_W-1:0] us_last(input int unsigned us);
    return USB_TIMER_W'(us - 1);
  endfunction

endpackage

// File: rtl/usbdev_us_timer.sv
// rtl/usbdev_us_timer.sv - saturating, clearable microsecond counter
module usbdev_us_timer #(
  parameter int unsigned Width = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_tick,
  output logic [Width-1:0] o_count
);

  logic [Width-1:0] r_count;

  // Clear wins over a coincident tick so a new window always starts from zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_tick && (r_count != {Width{1'b1}})) begin
      r_count <= r_count + Width'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/usbdev_wake_ctrl.sv
// rtl/usbdev_wake_ctrl.sv - USB device remote-wakeup sequencer (wait idle, drive K, await host)
module usbdev_wake_ctrl
  import usbdev_pkg::*;
#(
  parameter int unsigned SuspendMinUs  = SUSPEND_MIN_US_DEF,
  parameter int unsigned ResumeDriveUs = RESUME_DRIVE_US_DEF,
  parameter int unsigned HostWaitUs    = HOST_WAIT_US_DEF
) (
  input  logic       clk_48mhz_i,
  input  logic       rst_i,
  input  logic       us_tick_i,
  input  logic       link_suspend_i,
  input  logic       link_active_i,
  input  logic       link_disconnect_i,
  input  logic       link_reset_i,
  input  logic       rx_idle_det_i,
  input  logic       wake_en_i,
  input  logic       wake_req_i,
  output logic       resume_drive_o,
  output logic       resume_link_active_o,
  output logic       wake_done_o,
  output logic       wake_abort_o,
  output logic       wake_reject_o,
  output logic       wake_busy_o,
  output logic [2:0] wake_state_o
);

  localparam logic [USB_TIMER_W-1:0] SuspendLast = us_last(SuspendMinUs);
  localparam logic [USB_TIMER_W-1:0] DriveLast   = us_last(ResumeDriveUs);
  localparam logic [USB_TIMER_W-1:0] HostLast    = us_last(HostWaitUs);

  wake_state_e            r_state;
  wake_state_e            w_next;
  logic [USB_TIMER_W-1:0] w_count;
  logic                   w_timer_clr;
  logic                   w_kill;
  logic                   w_done;
  logic                   w_abort;
  logic                   w_reject;
  logic                   w_drive_nxt;
  logic                   w_link_act_nxt;
  logic                   w_busy_nxt;
  logic                   r_drive;
  logic                   r_link_act;
  logic                   r_done;
  logic                   r_abort;
  logic                   r_reject;
  logic                   r_busy;

  assign w_kill      = link_disconnect_i | link_reset_i;
  assign w_timer_clr = (w_next != r_state) ||
                       ((r_state == WAKE_WAIT_IDLE) && !rx_idle_det_i);

  usbdev_us_timer #(
    .Width (USB_TIMER_W)
  ) u_timer (
    .i_clk   (clk_48mhz_i),
    .i_rst   (rst_i),
    .i_clr   (w_timer_clr),
    .i_tick  (us_tick_i),
    .o_count (w_count)
  );

  always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= WAKE_IDLE;
      r_drive    <= 1'b0;
      r_link_act <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_reject   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_drive    <= w_drive_nxt;
      r_link_act <= w_link_act_nxt;
      r_done     <= w_done;
      r_abort    <= w_abort;
      r_reject   <= w_reject;
      r_busy     <= w_busy_nxt;
    end
  end

  // Abort conditions are tested before done so a coincident pair reports only the abort.
  always_comb begin
    w_next   = r_state;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    w_reject = 1'b0;
    unique case (r_state)
      WAKE_IDLE: begin
        if (wake_req_i) begin
          if (link_suspend_i && wake_en_i) begin
            w_next = WAKE_WAIT_IDLE;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      WAKE_WAIT_IDLE: begin
        if (w_kill || !wake_en_i || (!link_suspend_i && !link_active_i)) begin
          w_next  = WAKE_IDLE;
          w_abort = 1'b1;
        end else if (link_active_i) begin
          w_next = WAKE_IDLE;
          w_done = 1'b1;
        end else if (rx_idle_det_i && us_tick_i && (w_count == SuspendLast)) begin
          w_next = WAKE_DRIVE;
        end
      end
      WAKE_DRIVE: begin
        if (w_kill) begin
          w_next  = WAKE_IDLE;
          w_abort = 1'b1;
        end else if (us_tick_i && (w_count == DriveLast)) begin
          w_next = WAKE_HOST_WAIT;
        end
      end
      WAKE_HOST_WAIT: begin
        if (w_kill || (us_tick_i && (w_count == HostLast))) begin
          w_next  = WAKE_IDLE;
          w_abort = 1'b1;
        end else if (link_active_i) begin
          w_next = WAKE_IDLE;
          w_done = 1'b1;
        end
      end
      default: begin
        w_next = WAKE_IDLE;
      end
    endcase
  end

  always_comb begin
    w_drive_nxt    = (w_next == WAKE_DRIVE);
    w_link_act_nxt = (w_next == WAKE_DRIVE) && (r_state != WAKE_DRIVE);
    w_busy_nxt     = (w_next != WAKE_IDLE);
  end

  assign resume_drive_o       = r_drive;
  assign resume_link_active_o = r_link_act;
  assign wake_done_o          = r_done;
  assign wake_abort_o         = r_abort;
  assign wake_reject_o        = r_reject;
  assign wake_busy_o          = r_busy;
  assign wake_state_o         = r_state;

`ifndef SYNTHESIS
  a_state_valid: assert property (@(posedge clk_48mhz_i) disable iff (rst_i)
    r_state inside {WAKE_IDLE, WAKE_WAIT_IDLE, WAKE_DRIVE, WAKE_HOST_WAIT});

  a_drive_in_drive: assert property (@(posedge clk_48mhz_i) disable iff (rst_i)
    resume_drive_o |-> (r_state == WAKE_DRIVE));

  a_status_onehot: assert property (@(posedge clk_48mhz_i) disable iff (rst_i)
    $onehot0({wake_done_o, wake_abort_o, wake_reject_o}));
`endif

endmodule

// File: doc/usbdev_wake_ctrl.md
USBDEV_WAKE_CTRL -- requirements
Module: usbdev_wake_ctrl

Interface
REQ-001 The block SHALL have parameter SuspendMinUs, default 5000, giving the bus-idle time in microseconds required before remote wakeup.
REQ-002 The block SHALL have parameter ResumeDriveUs, default 2000, giving the K-drive duration in microseconds (legal range 1000-15000).
REQ-003 The block SHALL have parameter HostWaitUs, default 30000, giving the timeout in microseconds for the host to complete resume.
REQ-004 clk_48mhz_i  in  1  sole clock, 48 MHz.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 us_tick_i  in  1  one-cycle pulse, once per microsecond.
REQ-007 link_suspend_i / link_active_i / link_disconnect_i / link_reset_i  in  1 each  link-state levels.
REQ-008 rx_idle_det_i  in  1  high while the bus is idle (J).
REQ-009 wake_en_i  in  1  host-granted remote-wakeup enable (level).
REQ-010 wake_req_i  in  1  software wake request (pulse).
REQ-011 resume_drive_o  out  1  drive K on the bus (registered).
REQ-012 resume_link_active_o  out  1  one-cycle pulse to the link-state FSM to enter resuming.
REQ-013 wake_done_o / wake_abort_o / wake_reject_o  out  1 each  one-cycle status pulses.
REQ-014 wake_busy_o  out  1  high whenever the FSM is not Idle.
REQ-015 wake_state_o  out  3  current FSM state encoding.

Function
REQ-016 The FSM SHALL have states Idle=0, WaitIdle=1, Drive=2, HostWait=3.
REQ-017 A single 15-bit timer SHALL increment only on us_tick_i, SHALL be cleared on every state entry, and SHALL never wrap (saturating).
REQ-018 In Idle, wake_req_i with link_suspend_i=1 and wake_en_i=1 SHALL move the FSM to WaitIdle; otherwise wake_req_i SHALL produce wake_reject_o on the next cycle and the FSM SHALL stay in Idle.
REQ-019 wake_req_i outside Idle SHALL be ignored, with no reject pulse.
REQ-020 In WaitIdle, rx_idle_det_i=0 SHALL clear the timer.
REQ-021 In WaitIdle, the us_tick_i that makes the timer reach SuspendMinUs SHALL move the FSM to Drive.
REQ-022 In WaitIdle, link_active_i=1 (host resumed first) SHALL move the FSM to Idle and pulse wake_done_o.
REQ-023 In Drive, resume_drive_o SHALL be 1 starting the cycle after entry and SHALL stay 1 for exactly ResumeDriveUs ticks.
REQ-024 On entry to Drive, resume_link_active_o SHALL pulse once, coincident with the first resume_drive_o=1 cycle.
REQ-025 At the end of Drive the FSM SHALL move to HostWait, and resume_drive_o SHALL be 0 the following cycle.
REQ-026 In HostWait, link_active_i=1 SHALL move the FSM to Idle and pulse wake_done_o.
REQ-027 In HostWait, a timer value reaching HostWaitUs SHALL move the FSM to Idle and pulse wake_abort_o.
REQ-028 In any non-Idle state, link_disconnect_i=1 or link_reset_i=1 SHALL take priority over all other transitions: the FSM moves to Idle, resume_drive_o drops the next cycle, and wake_abort_o pulses.
REQ-029 In WaitIdle, wake_en_i falling or link_suspend_i falling without link_active_i SHALL abort the wake as in REQ-028.
REQ-030 When done and abort conditions occur in the same cycle, abort SHALL win; only one status pulse is ever emitted per request.
REQ-031 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-032 While rst_i=1, the state SHALL be Idle, the timer 0, and all outputs 0, including wake_state_o=0.
REQ-033 Assertion of rst_i mid-Drive SHALL release resume_drive_o asynchronously, with no status pulse.

Structure
REQ-034 The wake_state_e typedef and the default timing constants SHALL reside in the shared usbdev_pkg.
REQ-035 The block SHALL contain one natural sub-module, usbdev_us_timer (a saturating, clearable microsecond counter), which the link-state and SOF timers may also use.
REQ-036 The block SHALL carry assertions for: valid state, resume_drive_o implies Drive, and mutual exclusion of the status pulses.

Verification
REQ-037 Suspended with wake_en_i=1, then wake_req_i with the bus idle -> Drive entered 5000 ticks later, resume_drive_o high for exactly 2000 ticks, resume_link_active_o pulses once, link_active_i at tick 10000 -> wake_done_o.
REQ-038 wake_req_i with wake_en_i=0 -> wake_reject_o one cycle later, FSM stays Idle, resume_drive_o never asserts.
REQ-039 Bus activity at tick 4000 of WaitIdle -> timer restarts, and Drive starts 5000 ticks after the activity ends.
REQ-040 link_reset_i at tick 1000 of Drive -> resume_drive_o low the next cycle, wake_abort_o pulses, FSM returns to Idle.
REQ-041 No link_active_i after Drive -> wake_abort_o at HostWait tick 30000.
REQ-042 rst_i asserted mid-Drive -> outputs 0 immediately, no pulse, and a fresh request after reset behaves as in REQ-037.
